// File: rtl/bit_sync_chain.sv
// rtl/bit_sync_chain.sv - multi-flop single-bit synchronizer with synchronous reset
module bit_sync_chain #(
    parameter int   STAGES   = 3,
    parameter logic INIT_VAL = 1'b0
) (
    input  logic aclk,
    input  logic areset,
    input  logic d,
    output logic q
);

    // Only sync[0] can go metastable; it feeds nothing but sync[1].
    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync;

    always_ff @(posedge aclk) begin
        if (areset) begin
            sync <= {STAGES{INIT_VAL}};
        end else begin
            sync <= {sync[STAGES-2:0], d};
        end
    end

    assign q = sync[STAGES-1];

endmodule

// File: rtl/bit_cross_receiver.sv
// rtl/bit_cross_receiver.sv - synchronizes and stability-filters an async level, pulses on accepted edges
module bit_cross_receiver #(
    parameter int   SYNC_STAGES   = 3,
    parameter int   STABLE_CYCLES = 4,
    parameter logic INIT_VAL      = 1'b0
) (
    input  logic aclk,
    input  logic areset,
    input  logic bit_in,
    output logic bit_out,
    output logic bit_rise,
    output logic bit_fall,
    output logic ack_out,
    output logic filter_busy
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 10) begin : g_bad_sync_stages
        $error("bit_cross_receiver: SYNC_STAGES must be in 2..10");
    end
    if (STABLE_CYCLES < 1 || STABLE_CYCLES > 255) begin : g_bad_stable_cycles
        $error("bit_cross_receiver: STABLE_CYCLES must be in 1..255");
    end

    logic             cand;
    logic [CNT_W-1:0] cnt;

    bit_sync_chain #(
        .STAGES   (SYNC_STAGES),
        .INIT_VAL (INIT_VAL)
    ) u_sync (
        .aclk   (aclk),
        .areset (areset),
        .d      (bit_in),
        .q      (cand)
    );

    // Any edge where cand agrees with bit_out restarts qualification, dropping short glitches.
    always_ff @(posedge aclk) begin
        if (areset) begin
            bit_out  <= INIT_VAL;
            bit_rise <= 1'b0;
            bit_fall <= 1'b0;
            cnt      <= '0;
        end else begin
            bit_rise <= 1'b0;
            bit_fall <= 1'b0;
            if (cand == bit_out) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                bit_out  <= cand;
                bit_rise <= cand;
                bit_fall <= ~cand;
                cnt      <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign ack_out     = bit_out;
    assign filter_busy = (cnt != '0);

endmodule

// File: tb/tb_bit_cross_receiver.sv
// tb/tb_bit_cross_receiver.sv - randomized and directed checks of two receiver configurations against a history-based model
module tb_bit_cross_receiver;

    logic       clk = 1'b0;
    logic       areset;
    logic       bit_in;
    logic [1:0] bo, br, bf, ak, fb;

    bit_cross_receiver #(.SYNC_STAGES(3), .STABLE_CYCLES(4), .INIT_VAL(1'b0)) dut0 (
        .aclk(clk), .areset(areset), .bit_in(bit_in), .bit_out(bo[0]),
        .bit_rise(br[0]), .bit_fall(bf[0]), .ack_out(ak[0]), .filter_busy(fb[0])
    );

    bit_cross_receiver #(.SYNC_STAGES(2), .STABLE_CYCLES(1), .INIT_VAL(1'b1)) dut1 (
        .aclk(clk), .areset(areset), .bit_in(bit_in), .bit_out(bo[1]),
        .bit_rise(br[1]), .bit_fall(bf[1]), .ack_out(ak[1]), .filter_busy(fb[1])
    );

    always #5 clk = ~clk;

    int p_s  [2] = '{3, 2};
    int p_st [2] = '{4, 1};
    bit p_init [2] = '{1'b0, 1'b1};

    bit in_hist [0:32767];
    int edge_n = 0;
    int rst_edge = -1000;
    bit model_valid = 1'b0;
    bit m_out [2];
    bit m_rise [2];
    bit m_fall [2];
    bit m_busy [2];
    int m_since [2];
    int m_acc [2];
    int run;

    int tests = 0;
    int fails = 0;
    int rise_cnt [2];
    int fall_cnt [2];
    int rise_edge [2];
    int fall_edge [2];
    int busy_cyc0;
    int k, k2;

    // The value the filter sees at edge e is bit_in as sampled s edges earlier, unless that predates reset.
    function automatic bit cand_at(int e, int s, bit init);
        if (e - s > rst_edge) return in_hist[(e - s) & 32767];
        return init;
    endfunction

    // A change is accepted once cand has differed from the output on STABLE consecutive edges,
    // all of them after the previous acceptance or reset.
    always @(posedge clk) begin
        edge_n = edge_n + 1;
        in_hist[edge_n & 32767] = bit_in;
        if (areset) begin
            rst_edge    = edge_n;
            model_valid = 1'b1;
            for (int i = 0; i < 2; i++) begin
                m_out[i]   = p_init[i];
                m_rise[i]  = 1'b0;
                m_fall[i]  = 1'b0;
                m_busy[i]  = 1'b0;
                m_since[i] = edge_n;
            end
        end else if (model_valid) begin
            for (int i = 0; i < 2; i++) begin
                run = 0;
                for (int j = edge_n; j > m_since[i] && cand_at(j, p_s[i], p_init[i]) != m_out[i]; j--)
                    run = run + 1;
                if (run >= p_st[i]) begin
                    m_out[i]   = ~m_out[i];
                    m_rise[i]  = m_out[i];
                    m_fall[i]  = ~m_out[i];
                    m_busy[i]  = 1'b0;
                    m_since[i] = edge_n;
                    m_acc[i]   = m_acc[i] + 1;
                end else begin
                    m_rise[i] = 1'b0;
                    m_fall[i] = 1'b0;
                    m_busy[i] = (run > 0);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic act, input logic exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s at edge %0d: actual=%b expected=%b", nm, edge_n, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        tests = tests + 1;
        if (act != exp) begin
            fails = fails + 1;
            $display("FAIL %s: actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (model_valid) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("dut%0d.bit_out", i),     bo[i], m_out[i]);
                chk($sformatf("dut%0d.ack_out", i),     ak[i], m_out[i]);
                chk($sformatf("dut%0d.bit_rise", i),    br[i], m_rise[i]);
                chk($sformatf("dut%0d.bit_fall", i),    bf[i], m_fall[i]);
                chk($sformatf("dut%0d.filter_busy", i), fb[i], m_busy[i]);
                if (br[i] === 1'b1) begin
                    rise_cnt[i]  = rise_cnt[i] + 1;
                    rise_edge[i] = edge_n;
                end
                if (bf[i] === 1'b1) begin
                    fall_cnt[i]  = fall_cnt[i] + 1;
                    fall_edge[i] = edge_n;
                end
            end
            if (fb[0] === 1'b1) busy_cyc0 = busy_cyc0 + 1;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 2; i++) begin
            rise_cnt[i]  = 0;
            fall_cnt[i]  = 0;
            rise_edge[i] = -1;
            fall_edge[i] = -1;
            m_acc[i]     = 0;
        end
        busy_cyc0 = 0;
    endtask

    initial begin
        areset = 1'b1;
        bit_in = 1'b1;
        clear_counts();
        step(2);
        chk("t1_reset_bit_out0", bo[0], 1'b0);
        chk("t1_reset_busy0", fb[0], 1'b0);
        chk("t1_reset_rise0", br[0], 1'b0);
        chk("t1_reset_bit_out1", bo[1], 1'b1);

        clear_counts();
        areset = 1'b0;
        k = edge_n + 1;
        step(12);
        chk_int("t1_rise_count", rise_cnt[0], 1);
        chk_int("t1_rise_latency", rise_edge[0] - k, 6);
        chk("t1_model_out", m_out[0], 1'b1);
        chk_int("t1_dut1_pulses", rise_cnt[1] + fall_cnt[1], 0);

        bit_in = 1'b0;
        step(10);
        clear_counts();
        bit_in = 1'b1;
        k = edge_n + 1;
        step(20);
        bit_in = 1'b0;
        k2 = edge_n + 1;
        step(12);
        chk_int("t2_rise_count", rise_cnt[0], 1);
        chk_int("t2_fall_count", fall_cnt[0], 1);
        chk_int("t2_rise_latency", rise_edge[0] - k, 6);
        chk_int("t2_fall_latency", fall_edge[0] - k2, 6);
        chk_int("t6_rise_latency", rise_edge[1] - k, 2);
        chk_int("t6_fall_latency", fall_edge[1] - k2, 2);

        clear_counts();
        bit_in = 1'b1;
        step(3);
        bit_in = 1'b0;
        step(12);
        chk_int("t3_short_rises", rise_cnt[0], 0);
        chk_int("t3_short_falls", fall_cnt[0], 0);
        chk_int("t3_busy_cycles", busy_cyc0, 3);
        chk("t3_short_bit_out", bo[0], 1'b0);

        clear_counts();
        bit_in = 1'b1;
        step(4);
        bit_in = 1'b0;
        step(15);
        chk_int("t3_long_rises", rise_cnt[0], 1);
        chk_int("t3_long_falls", fall_cnt[0], 1);

        clear_counts();
        for (int i = 0; i < 30; i++) begin
            bit_in = ~bit_in;
            step(1);
        end
        bit_in = 1'b1;
        k = edge_n + 1;
        step(15);
        chk_int("t4_rises", rise_cnt[0], 1);
        chk_int("t4_falls", fall_cnt[0], 0);
        chk_int("t4_rise_latency", rise_edge[0] - k, 6);

        bit_in = 1'b0;
        step(12);
        bit_in = 1'b1;
        step(5);
        chk("t5_busy_before_reset", fb[0], 1'b1);
        clear_counts();
        areset = 1'b1;
        step(1);
        areset = 1'b0;
        chk("t5_bit_out_after_reset", bo[0], 1'b0);
        chk("t5_busy_after_reset", fb[0], 1'b0);
        chk("t5_rise_after_reset", br[0], 1'b0);
        chk("t5_dut1_bit_out_after_reset", bo[1], 1'b1);
        step(2);
        chk_int("t5_no_pulse", rise_cnt[0], 0);
        step(10);

        clear_counts();
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) == 0) bit_in = ~bit_in;
            areset = ($urandom_range(0, 2999) == 0);
            step(1);
        end
        areset = 1'b0;
        step(12);
        for (int i = 0; i < 2; i++)
            chk_int($sformatf("t6_dut%0d_pulse_count", i), rise_cnt[i] + fall_cnt[i], m_acc[i]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
